// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue handshake bundle: redirect, instruction-memory request/response, decode-facing head entry.
interface inst_fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_inst;
    logic        out_ready;

    modport master (
        output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_inst, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_pc4, out_inst
    );

    modport slave (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_inst, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_pc4, out_inst
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, tags them with their PC, buffers returned words
// in order and discards words belonging to fetches made obsolete by a redirect.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input logic               clk,
    input logic               rst,
    inst_fetch_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [CW-1:0] occ_q, occ_d, outst_q, outst_d, drop_q, drop_d;

    logic [31:0] pc_mem_q   [DEPTH];
    logic [31:0] inst_mem_q [DEPTH];
    logic [31:0] tag_mem_q  [DEPTH];

    logic          redirect, req_valid, req_fire, resp, enq, deq, not_empty;
    logic [SW-1:0] inflight;

    // Queued entries plus in-flight fetches (including ones to be dropped) never exceed DEPTH.
    assign redirect  = bus.redirect_valid;
    assign inflight  = {1'b0, occ_q} + {1'b0, outst_q};
    assign req_valid = !rst && !redirect && (inflight < SW'(DEPTH));
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign resp      = bus.imem_resp_valid;
    assign not_empty = (occ_q != '0);
    assign deq       = not_empty && bus.out_ready && !redirect;
    assign enq       = resp && (drop_q == '0) && !redirect;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.out_valid      = not_empty;
    assign bus.out_pc         = pc_mem_q[head_q];
    assign bus.out_pc4        = pc_mem_q[head_q] + 32'd4;
    assign bus.out_inst       = inst_mem_q[head_q];

    // Next-state: redirect overrides enqueue/dequeue and reloads the fetch address.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        occ_d      = occ_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(resp);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_wr_d   = tag_wr_q + PW'(1);
        end
        if (resp) begin
            tag_rd_d = tag_rd_q + PW'(1);
        end

        if (redirect) begin
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            occ_d      = '0;
            head_d     = tail_q;
            drop_d     = outst_q - CW'(resp);
        end else begin
            if (enq) tail_d = tail_q + PW'(1);
            if (deq) head_d = head_q + PW'(1);
            occ_d = occ_q + CW'(enq) - CW'(deq);
            if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            occ_q      <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[PW'(i)]   <= RESET_PC;
                inst_mem_q[PW'(i)] <= NOP;
                tag_mem_q[PW'(i)]  <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            occ_q      <= occ_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            if (req_fire) tag_mem_q[tag_wr_q] <= fetch_pc_q;
            if (enq) begin
                pc_mem_q[tail_q]   <= tag_mem_q[tag_rd_q];
                inst_mem_q[tail_q] <= bus.imem_resp_inst;
            end
        end
    end

    a_no_full_enq: assert property (@(posedge clk) disable iff (rst) enq |-> (occ_q < CW'(DEPTH)));
    a_resp_has_tag: assert property (@(posedge clk) disable iff (rst) resp |-> (outst_q != '0));
endmodule
